cache_flush_engine: RTL and testbench
=====================================

Name: cache_flush_engine

Overview:
- Cache-side responder for the one-cycle flush request pulses issued by the cache security controller (ic_flush_req / dc_flush_req).
- One instance per cache. On a request it walks every set and every way of the tag array. Valid+dirty lines are written back through a req/ack handshake (D-cache only). Every line is then invalidated.
- While walking it holds busy so the core-side pipeline stalls cache accesses. It signals completion with a single-cycle done pulse.

Parameters:
- SETS, 64, number of sets; power of two, >=2
- WAYS, 4, number of ways; power of two, >=1
- HAS_DIRTY, 1, 1 = write-back cache (D-cache); 0 = skip dirty check/writeback (I-cache)
- SET_W, $clog2(SETS), set index width (derived)
- WAY_W, (WAYS>1)?$clog2(WAYS):1, way index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_req  in  1  single-cycle flush request pulse from the security controller
- tag_rd_en  out  1  tag read strobe; data returns next cycle
- tag_rd_set  out  SET_W  set index being read
- tag_rd_way  out  WAY_W  way index being read
- tag_rd_valid  in  1  valid bit of the line read, 1-cycle latency
- tag_rd_dirty  in  1  dirty bit of the line read, 1-cycle latency; ignored when HAS_DIRTY=0
- tag_wr_en  out  1  invalidate strobe; clears valid and dirty at tag_wr_set/tag_wr_way
- tag_wr_set  out  SET_W  set index to invalidate
- tag_wr_way  out  WAY_W  way index to invalidate
- wb_req  out  1  writeback request; held until wb_ack
- wb_set  out  SET_W  set index of the line to write back
- wb_way  out  WAY_W  way index of the line to write back
- wb_ack  in  1  writeback accepted/complete
- busy  out  1  walk in progress; the cache must stall lookups and refills
- done  out  1  one-cycle pulse when a walk completes
- flush_cnt  out  16  saturating count of completed walks

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; set/way counters=0; pending=0; flush_cnt=0.
  - All strobes, busy and done = 0.
  - Reset mid-walk abandons the walk and drops any outstanding wb_req; the lines already invalidated stay invalid.
- Outputs:
  - All outputs are decoded from registered state (Moore); no combinational path from an input to an output.
  - Address outputs show the current set/way counters in every state.
- States: IDLE, RD, CHK, WB, INV, DONE.
  - IDLE: flush_req=1 -> RD, counters cleared.
  - RD: tag_rd_en=1 -> CHK.
  - CHK: if HAS_DIRTY && tag_rd_valid && tag_rd_dirty -> WB; otherwise -> INV. Valid/dirty are sampled in this cycle only.
  - WB: wb_req=1, held stable until the cycle wb_ack=1, then -> INV. wb_ack outside WB is ignored.
  - INV: tag_wr_en=1.
    - Way is the inner loop: way++.
    - On way wrap, set++ and way=0.
    - At set=SETS-1 and way=WAYS-1 -> DONE; otherwise -> RD.
  - DONE: done=1; flush_cnt+1, saturating at 0xFFFF. Then -> RD with counters cleared if pending (pending cleared), else -> IDLE.
- busy=1 in every state except IDLE. It is 1 in DONE and 0 on the first IDLE cycle.
- Latency:
  - flush_req sampled at edge N gives RD (busy=1) at cycle N+1.
  - A clean walk occupies 3*SETS*WAYS cycles plus 1 DONE cycle.
  - Each writeback adds (cycles in WB) to that.
- Coalescing:
  - flush_req while not IDLE, including in DONE, sets pending.
  - Multiple requests during one walk coalesce into one rerun.
  - A rerun always restarts from set 0, way 0, so every line is swept after the latest request.
- The way mask is not consulted; masked ways are flushed too, so stale data cannot survive in a disabled way.

Decomposition:
- Shared package cache_sec_pkg:
  - state enum type flush_state_e (IDLE, RD, CHK, WB, INV, DONE)
  - FLUSH_CNT_W=16 constant
  - the helper function for way-width derivation
- One natural sub-module: flush_walk_ctr (set/way counter with clear, step and last-line flag), reusable by a future prefetch or scrub walker.
- The FSM stays in the top.

Test Plan (SETS=4, WAYS=2, HAS_DIRTY=1 unless stated):
1. Clean flush: all lines invalid; flush_req at cycle 0 -> busy 1 from cycle 1 for 25 cycles; 8 tag_wr_en pulses covering (0,0),(0,1),(1,0)...(3,1) in order; done pulse at cycle 25; flush_cnt=1; no wb_req.
2. Dirty line: (2,1) valid+dirty; wb_ack delayed 5 cycles -> wb_req held with wb_set=2, wb_way=1 for 5 cycles; tag_wr_en for (2,1) only after ack; walk time 24+5+1.
3. HAS_DIRTY=0: all lines valid+dirty -> wb_req never asserts; walk takes 25 cycles.
4. Coalescing: three flush_req pulses during a walk plus one in the DONE cycle -> exactly one rerun starting at (0,0); flush_cnt=2; busy never drops between the two walks.
5. Reset mid-walk: rst_n low while in WB at set 1 -> all outputs 0 immediately; a later flush_req restarts at (0,0) with flush_cnt=0.
6. Saturation: preload flush_cnt near 0xFFFF (force/fast walks) -> stays at 0xFFFF after a further walk.

Source files
------------

// File: rtl/cache_sec_pkg.sv
// Shared types and constants for the cache security blocks.
package cache_sec_pkg;

    localparam int unsigned FLUSH_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        WB,
        INV,
        DONE
    } flush_state_e;

    // A single-way cache still needs a 1-bit way index so ports never collapse to zero width.
    function automatic int unsigned way_width(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/flush_walk_ctr.sv
// Set/way walk counter: way is the inner loop, set the outer loop.
module flush_walk_ctr
    import cache_sec_pkg::*;
#(
    parameter int unsigned SETS  = 64,
    parameter int unsigned WAYS  = 4,
    parameter int unsigned SET_W = $clog2(SETS),
    parameter int unsigned WAY_W = way_width(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             step_i,
    output logic [SET_W-1:0] set_o,
    output logic [WAY_W-1:0] way_o,
    output logic             last_o
);

    localparam logic [SET_W-1:0] SetLast = SET_W'(SETS - 1);
    localparam logic [WAY_W-1:0] WayLast = WAY_W'(WAYS - 1);

    logic [SET_W-1:0] set_q, set_d;
    logic [WAY_W-1:0] way_q, way_d;

    // Next position: clear wins over step; way wrap carries into set.
    always_comb begin
        set_d = set_q;
        way_d = way_q;
        if (clr_i) begin
            set_d = '0;
            way_d = '0;
        end else if (step_i) begin
            if (way_q == WayLast) begin
                way_d = '0;
                set_d = set_q + 1'b1;
            end else begin
                way_d = way_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q <= '0;
            way_q <= '0;
        end else begin
            set_q <= set_d;
            way_q <= way_d;
        end
    end

    // Output decode from registered position.
    always_comb begin
        set_o  = set_q;
        way_o  = way_q;
        last_o = (set_q == SetLast) && (way_q == WayLast);
    end

endmodule

// File: rtl/cache_flush_engine.sv
// Cache flush walker: reads every tag, writes back dirty lines, invalidates all lines.
module cache_flush_engine
    import cache_sec_pkg::*;
#(
    parameter int unsigned SETS      = 64,
    parameter int unsigned WAYS      = 4,
    parameter bit          HAS_DIRTY = 1'b1,
    parameter int unsigned SET_W     = $clog2(SETS),
    parameter int unsigned WAY_W     = way_width(WAYS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_req,
    output logic                   tag_rd_en,
    output logic [SET_W-1:0]       tag_rd_set,
    output logic [WAY_W-1:0]       tag_rd_way,
    input  logic                   tag_rd_valid,
    input  logic                   tag_rd_dirty,
    output logic                   tag_wr_en,
    output logic [SET_W-1:0]       tag_wr_set,
    output logic [WAY_W-1:0]       tag_wr_way,
    output logic                   wb_req,
    output logic [SET_W-1:0]       wb_set,
    output logic [WAY_W-1:0]       wb_way,
    input  logic                   wb_ack,
    output logic                   busy,
    output logic                   done,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
);

    flush_state_e           state_q, state_d;
    logic                   pending_q, pending_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             ctr_clr;
    logic             ctr_step;
    logic [SET_W-1:0] cur_set;
    logic [WAY_W-1:0] cur_way;
    logic             cur_last;

    flush_walk_ctr #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .SET_W (SET_W),
        .WAY_W (WAY_W)
    ) u_walk_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (ctr_clr),
        .step_i (ctr_step),
        .set_o  (cur_set),
        .way_o  (cur_way),
        .last_o (cur_last)
    );

    // Next-state, pending-request and completion-counter logic.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        flush_cnt_d = flush_cnt_q;
        ctr_clr     = 1'b0;
        ctr_step    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = RD;
                    ctr_clr = 1'b1;
                end
            end
            RD: begin
                state_d = CHK;
            end
            CHK: begin
                // Tag data for the line read in RD is only valid in this cycle.
                if (HAS_DIRTY && tag_rd_valid && tag_rd_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = INV;
                end
            end
            WB: begin
                if (wb_ack) begin
                    state_d = INV;
                end
            end
            INV: begin
                ctr_step = 1'b1;
                state_d  = cur_last ? DONE : RD;
            end
            DONE: begin
                if (flush_cnt_q != '1) begin
                    flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
                end
                // A request landing in DONE itself must not be lost, so it counts as pending.
                if (pending_q || flush_req) begin
                    state_d   = RD;
                    ctr_clr   = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any number of requests during a walk collapse into a single full rerun.
        if (flush_req && (state_q inside {RD, CHK, WB, INV})) begin
            pending_d = 1'b1;
        end
    end

    // State, pending flag and completion counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Moore output decode: strobes from state, addresses from the walk counter.
    always_comb begin
        tag_rd_en  = (state_q == RD);
        tag_wr_en  = (state_q == INV);
        wb_req     = (state_q == WB);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        tag_rd_set = cur_set;
        tag_rd_way = cur_way;
        tag_wr_set = cur_set;
        tag_wr_way = cur_way;
        wb_set     = cur_set;
        wb_way     = cur_way;
        flush_cnt  = flush_cnt_q;
    end

endmodule

// File: tb/tb_cache_flush_engine.sv
// Self-checking bench for cache_flush_engine (SETS=4, WAYS=2) with a tag/writeback environment.
module tb_cache_flush_engine;

    localparam int unsigned SETS  = 4;
    localparam int unsigned WAYS  = 2;
    localparam int unsigned SET_W = 2;
    localparam int unsigned WAY_W = 1;
    localparam int          LINES = SETS * WAYS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_req = 1'b0;
    logic flush_req_ic = 1'b0;

    logic             tag_rd_en, tag_wr_en, wb_req, wb_ack, busy, done;
    logic [SET_W-1:0] tag_rd_set, tag_wr_set, wb_set;
    logic [WAY_W-1:0] tag_rd_way, tag_wr_way, wb_way;
    logic [15:0]      flush_cnt;
    logic             tag_rd_valid = 1'b0;
    logic             tag_rd_dirty = 1'b0;

    logic             ic_tag_rd_en, ic_tag_wr_en, ic_wb_req, ic_busy, ic_done;
    logic [SET_W-1:0] ic_tag_rd_set, ic_tag_wr_set, ic_wb_set;
    logic [WAY_W-1:0] ic_tag_rd_way, ic_tag_wr_way, ic_wb_way;
    logic [15:0]      ic_flush_cnt;

    // Environment state set up by the tests.
    bit valid_m [LINES];
    bit dirty_m [LINES];
    int epoch;
    int wb_delay;
    bit stray_en;

    // Environment state owned by the clocked tag model.
    int inv_epoch [LINES];
    int wb_cnt = 0;
    bit stray_bit = 1'b0;

    int n_checks;
    int n_fail;
    int exp_cnt;
    int ev_q[$];
    int exp_q[$];
    int done_ks[$];
    int req_ks[$];

    int rd_idx, wr_idx, wb_idx, ic_wr_idx;
    assign rd_idx    = int'(tag_rd_set) * WAYS + int'(tag_rd_way);
    assign wr_idx    = int'(tag_wr_set) * WAYS + int'(tag_wr_way);
    assign wb_idx    = int'(wb_set) * WAYS + int'(wb_way);
    assign ic_wr_idx = int'(ic_tag_wr_set) * WAYS + int'(ic_tag_wr_way);

    // Writeback port accepts after wb_delay cycles; stray acks outside WB must be ignored.
    assign wb_ack = wb_req ? (wb_cnt == wb_delay - 1) : (stray_en && stray_bit);

    always #5 clk = ~clk;

    cache_flush_engine #(
        .SETS      (SETS),
        .WAYS      (WAYS),
        .HAS_DIRTY (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_req    (flush_req),
        .tag_rd_en    (tag_rd_en),
        .tag_rd_set   (tag_rd_set),
        .tag_rd_way   (tag_rd_way),
        .tag_rd_valid (tag_rd_valid),
        .tag_rd_dirty (tag_rd_dirty),
        .tag_wr_en    (tag_wr_en),
        .tag_wr_set   (tag_wr_set),
        .tag_wr_way   (tag_wr_way),
        .wb_req       (wb_req),
        .wb_set       (wb_set),
        .wb_way       (wb_way),
        .wb_ack       (wb_ack),
        .busy         (busy),
        .done         (done),
        .flush_cnt    (flush_cnt)
    );

    // I-cache flavour: every line reads back valid+dirty, nothing may be written back.
    cache_flush_engine #(
        .SETS      (SETS),
        .WAYS      (WAYS),
        .HAS_DIRTY (1'b0)
    ) dut_ic (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_req    (flush_req_ic),
        .tag_rd_en    (ic_tag_rd_en),
        .tag_rd_set   (ic_tag_rd_set),
        .tag_rd_way   (ic_tag_rd_way),
        .tag_rd_valid (1'b1),
        .tag_rd_dirty (1'b1),
        .tag_wr_en    (ic_tag_wr_en),
        .tag_wr_set   (ic_tag_wr_set),
        .tag_wr_way   (ic_tag_wr_way),
        .wb_req       (ic_wb_req),
        .wb_set       (ic_wb_set),
        .wb_way       (ic_wb_way),
        .wb_ack       (1'b0),
        .busy         (ic_busy),
        .done         (ic_done),
        .flush_cnt    (ic_flush_cnt)
    );

    // Tag array with 1-cycle read latency; random data outside the read-return cycle.
    always @(posedge clk) begin
        if (tag_rd_en) begin
            tag_rd_valid <= valid_m[rd_idx] && (inv_epoch[rd_idx] != epoch);
            tag_rd_dirty <= dirty_m[rd_idx];
        end else begin
            tag_rd_valid <= 1'($urandom);
            tag_rd_dirty <= 1'($urandom);
        end
        if (tag_wr_en) inv_epoch[wr_idx] <= epoch;
        if (wb_req && !wb_ack) wb_cnt <= wb_cnt + 1;
        else wb_cnt <= 0;
        stray_bit <= 1'($urandom);
    end

    // Reference: expected event stream of one walk (100+i = writeback of line i, i = invalidate).
    // Returns the walk length in cycles including DONE.
    function automatic int exp_push_walk(input bit fresh);
        int n_wb = 0;
        for (int i = 0; i < LINES; i++) begin
            if (fresh && valid_m[i] && dirty_m[i]) begin
                exp_q.push_back(100 + i);
                n_wb++;
            end
            exp_q.push_back(i);
        end
        return 3 * LINES + 1 + n_wb * wb_delay;
    endfunction

    function automatic int seq_diff();
        int n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (ev_q[i] != exp_q[i]) return i;
        if (ev_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int got_at(input int i);
        return (i >= 0 && i < ev_q.size()) ? ev_q[i] : -1;
    endfunction

    function automatic int exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : -1;
    endfunction

    function automatic int sat_inc(input int c);
        return (c < 65535) ? c + 1 : 65535;
    endfunction

    task automatic load_lines(input bit rnd_valid, input bit rnd_dirty);
        epoch++;
        for (int i = 0; i < LINES; i++) begin
            valid_m[i] = rnd_valid ? 1'($urandom) : 1'b0;
            dirty_m[i] = rnd_dirty ? 1'($urandom) : 1'b0;
        end
    endtask

    task automatic start_flush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    // Records events cycle by cycle (cycle 1 = first busy cycle) until n_done done pulses.
    task automatic observe(input int n_done, input int budget, output int busy_cnt,
                           output int wbreq_cnt, output int unstable, output bit timeout);
        int  k = 1;
        bit  prev_wb = 1'b0;
        int  prev_idx = 0;
        busy_cnt = 0;
        wbreq_cnt = 0;
        unstable = 0;
        ev_q.delete();
        done_ks.delete();
        while (done_ks.size() < n_done && k <= budget) begin
            flush_req = 1'b0;
            foreach (req_ks[j]) if (req_ks[j] == k) flush_req = 1'b1;
            if (busy) busy_cnt++;
            if (tag_wr_en) ev_q.push_back(wr_idx);
            if (wb_req) begin
                wbreq_cnt++;
                if (wb_ack) ev_q.push_back(100 + wb_idx);
                if (prev_wb && wb_idx != prev_idx) unstable++;
            end
            prev_wb = wb_req;
            prev_idx = wb_idx;
            if (done) done_ks.push_back(k);
            @(negedge clk);
            k++;
        end
        flush_req = 1'b0;
        req_ks.delete();
        timeout = (done_ks.size() < n_done);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, tag_rd_en, tag_wr_en, wb_req} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {busy, done, tag_rd_en, tag_wr_en, wb_req});
        end
        n_checks++;
        if (flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0000", flush_cnt);
        end
        n_checks++;
        if ({tag_rd_set, tag_rd_way, wb_set, wb_way} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_addr: got %b want 000000",
                     {tag_rd_set, tag_rd_way, wb_set, wb_way});
        end
        n_checks++;
        if ({ic_busy, ic_done, ic_wb_req, ic_flush_cnt} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_ic: got %h want 0", {ic_busy, ic_done, ic_wb_req, ic_flush_cnt});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy got %b want 0", busy);
        end
    endtask

    task automatic test_clean();
        int len, bc, wq, un, d;
        bit to;
        load_lines(1'b0, 1'b1);
        wb_delay = 3;
        stray_en = 1'b1;
        exp_q.delete();
        len = exp_push_walk(1'b1);
        start_flush();
        n_checks++;
        if ({busy, tag_rd_en, tag_rd_set, tag_rd_way} !== 5'b11000) begin
            n_fail++;
            $display("FAIL clean_first_cycle: got %b want 11000",
                     {busy, tag_rd_en, tag_rd_set, tag_rd_way});
        end
        observe(1, 200, bc, wq, un, to);
        exp_cnt = sat_inc(exp_cnt);
        n_checks++;
        if (to || done_ks[0] != len) begin
            n_fail++;
            $display("FAIL clean_done_cycle: got %0d want %0d", to ? -1 : done_ks[0], len);
        end
        n_checks++;
        if (bc != len || wq != 0) begin
            n_fail++;
            $display("FAIL clean_busy_wb: busy %0d wb %0d want busy %0d wb 0", bc, wq, len);
        end
        d = seq_diff();
        n_checks++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL clean_seq: event %0d got %0d want %0d", d, got_at(d), exp_at(d));
        end
        n_checks++;
        if (busy !== 1'b0 || flush_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL clean_after: busy %b cnt %0d want busy 0 cnt %0d",
                     busy, flush_cnt, exp_cnt);
        end
    endtask

    task automatic test_dirty();
        int len, bc, wq, un, d;
        bit to;
        load_lines(1'b0, 1'b0);
        valid_m[5] = 1'b1;
        dirty_m[5] = 1'b1;
        valid_m[1] = 1'b1;
        wb_delay = 5;
        stray_en = 1'b1;
        exp_q.delete();
        len = exp_push_walk(1'b1);
        start_flush();
        observe(1, 200, bc, wq, un, to);
        exp_cnt = sat_inc(exp_cnt);
        n_checks++;
        if (to || done_ks[0] != len) begin
            n_fail++;
            $display("FAIL dirty_done_cycle: got %0d want %0d", to ? -1 : done_ks[0], len);
        end
        n_checks++;
        if (wq != 5 || un != 0) begin
            n_fail++;
            $display("FAIL dirty_wb_hold: cycles %0d addr changes %0d want 5 and 0", wq, un);
        end
        d = seq_diff();
        n_checks++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL dirty_seq: event %0d got %0d want %0d", d, got_at(d), exp_at(d));
        end
        n_checks++;
        if (flush_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL dirty_cnt: got %0d want %0d", flush_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        int len, bc, wq, un, d;
        bit to;
        for (int it = 0; it < 6; it++) begin
            load_lines(1'b1, 1'b1);
            wb_delay = $urandom_range(1, 4);
            stray_en = 1'b1;
            exp_q.delete();
            len = exp_push_walk(1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_flush();
            observe(1, 300, bc, wq, un, to);
            exp_cnt = sat_inc(exp_cnt);
            n_checks++;
            if (to || done_ks[0] != len || bc != len) begin
                n_fail++;
                $display("FAIL rand%0d_len: done %0d busy %0d want %0d", it,
                         to ? -1 : done_ks[0], bc, len);
            end
            d = seq_diff();
            n_checks++;
            if (d >= 0 || wq != len - (3 * LINES + 1) || un != 0) begin
                n_fail++;
                $display("FAIL rand%0d_seq: event %0d got %0d want %0d, wb cycles %0d want %0d",
                         it, d, got_at(d), exp_at(d), wq, len - (3 * LINES + 1));
            end
            n_checks++;
            if (busy !== 1'b0 || flush_cnt !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL rand%0d_after: busy %b cnt %0d want 0 %0d", it, busy,
                         flush_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_no_dirty();
        int k = 1;
        int dk = -1;
        int bc = 0;
        int wq = 0;
        int inv[$];
        bit order_ok;
        flush_req_ic = 1'b1;
        @(negedge clk);
        flush_req_ic = 1'b0;
        while (k <= 100 && dk < 0) begin
            if (ic_busy) bc++;
            if (ic_wb_req) wq++;
            if (ic_tag_wr_en) inv.push_back(ic_wr_idx);
            if (ic_done) dk = k;
            @(negedge clk);
            k++;
        end
        order_ok = (inv.size() == LINES);
        foreach (inv[i]) if (inv[i] != i) order_ok = 1'b0;
        n_checks++;
        if (dk != 3 * LINES + 1 || bc != 3 * LINES + 1) begin
            n_fail++;
            $display("FAIL ic_len: done %0d busy %0d want %0d", dk, bc, 3 * LINES + 1);
        end
        n_checks++;
        if (wq != 0 || !order_ok) begin
            n_fail++;
            $display("FAIL ic_wb_inv: wb cycles %0d inv %0d in order %b want 0 %0d 1",
                     wq, inv.size(), order_ok, LINES);
        end
        n_checks++;
        if (ic_busy !== 1'b0 || ic_flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL ic_after: busy %b cnt %0d want 0 1", ic_busy, ic_flush_cnt);
        end
    endtask

    task automatic test_coalesce();
        int len1, len2, bc, wq, un, d;
        bit to;
        load_lines(1'b0, 1'b0);
        valid_m[3] = 1'b1;
        dirty_m[3] = 1'b1;
        wb_delay = 2;
        stray_en = 1'b0;
        exp_q.delete();
        len1 = exp_push_walk(1'b1);
        len2 = exp_push_walk(1'b0);
        req_ks = '{3, 10, 17, len1};
        start_flush();
        observe(2, 300, bc, wq, un, to);
        exp_cnt = sat_inc(sat_inc(exp_cnt));
        n_checks++;
        if (to || done_ks[0] != len1 || done_ks[1] != len1 + len2) begin
            n_fail++;
            $display("FAIL coal_done: got %0d pulses want done at %0d and %0d",
                     done_ks.size(), len1, len1 + len2);
        end
        n_checks++;
        if (bc != len1 + len2) begin
            n_fail++;
            $display("FAIL coal_busy: got %0d busy cycles want %0d", bc, len1 + len2);
        end
        d = seq_diff();
        n_checks++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL coal_seq: event %0d got %0d want %0d", d, got_at(d), exp_at(d));
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || flush_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL coal_after: busy %b cnt %0d want 0 %0d", busy, flush_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_midwalk();
        int k = 0;
        int len, bc, wq, un, d;
        bit to;
        load_lines(1'b0, 1'b0);
        valid_m[2] = 1'b1;
        dirty_m[2] = 1'b1;
        wb_delay = 40;
        stray_en = 1'b0;
        start_flush();
        while (wb_req !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if ({wb_req, wb_set, wb_way} !== 4'b1010) begin
            n_fail++;
            $display("FAIL midwalk_wb: got %b want 1010", {wb_req, wb_set, wb_way});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, tag_rd_en, tag_wr_en, wb_req, flush_cnt} !== 21'b0) begin
            n_fail++;
            $display("FAIL midwalk_reset: got %h want 0",
                     {busy, done, tag_rd_en, tag_wr_en, wb_req, flush_cnt});
        end
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_lines(1'b0, 1'b0);
        wb_delay = 1;
        exp_q.delete();
        len = exp_push_walk(1'b1);
        start_flush();
        n_checks++;
        if ({busy, tag_rd_en, tag_rd_set, tag_rd_way} !== 5'b11000) begin
            n_fail++;
            $display("FAIL restart_first: got %b want 11000",
                     {busy, tag_rd_en, tag_rd_set, tag_rd_way});
        end
        observe(1, 200, bc, wq, un, to);
        exp_cnt = sat_inc(exp_cnt);
        d = seq_diff();
        n_checks++;
        if (to || d >= 0 || done_ks[0] != len) begin
            n_fail++;
            $display("FAIL restart_walk: event %0d got %0d want %0d", d, got_at(d), exp_at(d));
        end
        n_checks++;
        if (flush_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL restart_cnt: got %0d want %0d", flush_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturate();
        int bc, wq, un;
        bit to;
        @(negedge clk);
        force dut.flush_cnt_q = 16'hFFFE;
        #1;
        release dut.flush_cnt_q;
        exp_cnt = 65534;
        for (int it = 0; it < 2; it++) begin
            load_lines(1'b0, 1'b0);
            start_flush();
            observe(1, 200, bc, wq, un, to);
            exp_cnt = sat_inc(exp_cnt);
            n_checks++;
            if (to || flush_cnt !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL sat%0d_cnt: got %h want %h", it, flush_cnt, 16'(exp_cnt));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        epoch = 1;
        wb_delay = 1;
        stray_en = 1'b0;
        exp_cnt = 0;
        test_reset();
        test_clean();
        test_dirty();
        test_random();
        test_no_dirty();
        test_coalesce();
        test_reset_midwalk();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

endmodule
